// File: rtl/oric_ram_arbiter.sv
// oric_ram_arbiter: request/grant arbiter sharing one external SRAM among NUM_CH clients.
// Optional write protection of the region at/above WPROT_BASE when ORIC_RAM_ARB_WPROT_EN is defined.
`default_nettype none

module oric_ram_arbiter #(
    parameter int NUM_CH  = 4,
    parameter int AW      = 16,
    parameter int DW      = 8,
    parameter int ACC_CYC = 2,
    parameter int PRIO0   = 1
`ifdef ORIC_RAM_ARB_WPROT_EN
    ,
    parameter logic [AW-1:0] WPROT_BASE = 16'hC000
`endif
) (
    input  logic                 CLK_IN,
    input  logic                 RESETn,
    input  logic [NUM_CH-1:0]    req,
    input  logic [NUM_CH-1:0]    we,
    input  logic [NUM_CH*AW-1:0] addr,
    input  logic [NUM_CH*DW-1:0] wdata,
    output logic [NUM_CH-1:0]    gnt,
    output logic [NUM_CH-1:0]    rvalid,
    output logic [DW-1:0]        rdata,
    output logic                 busy,
    output logic [AW-1:0]        ram_ad,
    output logic [DW-1:0]        ram_d,
    input  logic [DW-1:0]        ram_q,
    output logic                 ram_cs,
    output logic                 ram_oe,
    output logic                 ram_we
`ifdef ORIC_RAM_ARB_WPROT_EN
    ,
    input  logic                 wprot,
    output logic                 wp_hit
`endif
);

    localparam int PW = $clog2(NUM_CH);
    localparam int CW = 4;

    typedef enum logic [0:0] {
        S_IDLE   = 1'b0,
        S_ACCESS = 1'b1
    } state_t;

    state_t              state_q, state_d;
    logic [CW-1:0]       cnt_q, cnt_d;
    logic [PW-1:0]       ptr_q, ptr_d;
    logic [PW-1:0]       win_q, win_d;
    logic                rd_q, rd_d;
    logic [NUM_CH-1:0]   gnt_q, gnt_d;
    logic [NUM_CH-1:0]   rvalid_q, rvalid_d;
    logic [DW-1:0]       rdata_q, rdata_d;
    logic                busy_q, busy_d;
    logic [AW-1:0]       ram_ad_q, ram_ad_d;
    logic [DW-1:0]       ram_d_q, ram_d_d;
    logic                cs_q, cs_d;
    logic                oe_q, oe_d;
    logic                we_q, we_d;
    logic                wph_q, wph_d;

    logic [AW-1:0]       addr_a  [NUM_CH];
    logic [DW-1:0]       wdata_a [NUM_CH];

    generate
        for (genvar i = 0; i < NUM_CH; i++) begin : g_unpack
            assign addr_a[i]  = addr[i*AW +: AW];
            assign wdata_a[i] = wdata[i*DW +: DW];
        end
    endgenerate

    // Winner selection: channel 0 pre-empts when PRIO0 is set, otherwise
    // first requester scanning upward from the round-robin pointer.
    logic          arb_found;
    logic          arb_prio;
    logic [PW-1:0] arb_win;
    logic [PW:0]   scan;
    logic [PW-1:0] scan_idx;

    always_comb begin
        arb_found = 1'b0;
        arb_prio  = 1'b0;
        arb_win   = '0;
        scan      = '0;
        scan_idx  = '0;
        if (PRIO0 != 0 && req[0]) begin
            arb_found = 1'b1;
            arb_prio  = 1'b1;
        end else begin
            for (int k = 0; k < NUM_CH; k++) begin
                scan = {1'b0, ptr_q} + (PW+1)'(k);
                if (scan >= (PW+1)'(NUM_CH)) begin
                    scan = scan - (PW+1)'(NUM_CH);
                end
                scan_idx = scan[PW-1:0];
                if (!arb_found && req[scan_idx] && !(PRIO0 != 0 && scan_idx == '0)) begin
                    arb_found = 1'b1;
                    arb_win   = scan_idx;
                end
            end
        end
    end

    logic w_wr;
    logic w_blk;

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        ptr_d    = ptr_q;
        win_d    = win_q;
        rd_d     = rd_q;
        gnt_d    = '0;
        rvalid_d = '0;
        rdata_d  = rdata_q;
        busy_d   = busy_q;
        ram_ad_d = ram_ad_q;
        ram_d_d  = ram_d_q;
        cs_d     = cs_q;
        oe_d     = oe_q;
        we_d     = we_q;
        wph_d    = 1'b0;
        w_wr     = 1'b0;
        w_blk    = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (arb_found) begin
                    w_wr = we[arb_win];
`ifdef ORIC_RAM_ARB_WPROT_EN
                    w_blk = w_wr && wprot && (addr_a[arb_win] >= WPROT_BASE);
`endif
                    gnt_d[arb_win] = 1'b1;
                    ram_ad_d = addr_a[arb_win];
                    ram_d_d  = wdata_a[arb_win];
                    cs_d     = 1'b1;
                    oe_d     = ~w_wr;
                    we_d     = w_wr & ~w_blk;
                    wph_d    = w_blk;
                    busy_d   = 1'b1;
                    cnt_d    = '0;
                    rd_d     = ~w_wr;
                    win_d    = arb_win;
                    state_d  = S_ACCESS;
                    if (!arb_prio) begin
                        ptr_d = (arb_win == PW'(NUM_CH-1)) ? '0 : arb_win + PW'(1);
                    end
                end
            end
            S_ACCESS: begin
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(ACC_CYC-1)) begin
                    cs_d    = 1'b0;
                    oe_d    = 1'b0;
                    we_d    = 1'b0;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                    if (rd_q) begin
                        rdata_d         = ram_q;
                        rvalid_d[win_q] = 1'b1;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge CLK_IN or negedge RESETn) begin
        if (!RESETn) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            ptr_q    <= PW'(1);
            win_q    <= '0;
            rd_q     <= 1'b0;
            gnt_q    <= '0;
            rvalid_q <= '0;
            rdata_q  <= '0;
            busy_q   <= 1'b0;
            ram_ad_q <= '0;
            ram_d_q  <= '0;
            cs_q     <= 1'b0;
            oe_q     <= 1'b0;
            we_q     <= 1'b0;
            wph_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            ptr_q    <= ptr_d;
            win_q    <= win_d;
            rd_q     <= rd_d;
            gnt_q    <= gnt_d;
            rvalid_q <= rvalid_d;
            rdata_q  <= rdata_d;
            busy_q   <= busy_d;
            ram_ad_q <= ram_ad_d;
            ram_d_q  <= ram_d_d;
            cs_q     <= cs_d;
            oe_q     <= oe_d;
            we_q     <= we_d;
            wph_q    <= wph_d;
        end
    end

    assign gnt    = gnt_q;
    assign rvalid = rvalid_q;
    assign rdata  = rdata_q;
    assign busy   = busy_q;
    assign ram_ad = ram_ad_q;
    assign ram_d  = ram_d_q;
    assign ram_cs = cs_q;
    assign ram_oe = oe_q;
    assign ram_we = we_q;
`ifdef ORIC_RAM_ARB_WPROT_EN
    assign wp_hit = wph_q;
`else
    logic unused_wph;
    assign unused_wph = wph_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_oric_ram_arbiter.sv
// tb_oric_ram_arbiter: directed checks of grant timing, arbitration order, reset abort and write protection.
`default_nettype none

module tb_oric_ram_arbiter;

    logic        CLK_IN;
    logic        RESETn;
    logic [3:0]  req;
    logic [3:0]  we;
    logic [63:0] addr;
    logic [31:0] wdata;
    logic [7:0]  ram_q;

    logic [3:0]  gnt, rvalid;
    logic [7:0]  rdata, ram_d;
    logic [15:0] ram_ad;
    logic        busy, ram_cs, ram_oe, ram_we;

    logic [3:0]  gnt_rr, rvalid_rr;
    logic [7:0]  rdata_rr, ram_d_rr;
    logic [15:0] ram_ad_rr;
    logic        busy_rr, ram_cs_rr, ram_oe_rr, ram_we_rr;

`ifdef ORIC_RAM_ARB_WPROT_EN
    logic        wprot;
    logic        wp_hit, wp_hit_rr;
`endif

    int n_checks = 0;
    int n_errors = 0;

    oric_ram_arbiter #(.NUM_CH(4), .AW(16), .DW(8), .ACC_CYC(2), .PRIO0(1)) dut (
        .CLK_IN(CLK_IN), .RESETn(RESETn), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .gnt(gnt), .rvalid(rvalid), .rdata(rdata), .busy(busy), .ram_ad(ram_ad), .ram_d(ram_d),
        .ram_q(ram_q), .ram_cs(ram_cs), .ram_oe(ram_oe), .ram_we(ram_we)
`ifdef ORIC_RAM_ARB_WPROT_EN
        , .wprot(wprot), .wp_hit(wp_hit)
`endif
    );

    oric_ram_arbiter #(.NUM_CH(4), .AW(16), .DW(8), .ACC_CYC(2), .PRIO0(0)) dut_rr (
        .CLK_IN(CLK_IN), .RESETn(RESETn), .req(req), .we(we), .addr(addr), .wdata(wdata),
        .gnt(gnt_rr), .rvalid(rvalid_rr), .rdata(rdata_rr), .busy(busy_rr), .ram_ad(ram_ad_rr),
        .ram_d(ram_d_rr), .ram_q(ram_q), .ram_cs(ram_cs_rr), .ram_oe(ram_oe_rr), .ram_we(ram_we_rr)
`ifdef ORIC_RAM_ARB_WPROT_EN
        , .wprot(wprot), .wp_hit(wp_hit_rr)
`endif
    );

    initial CLK_IN = 1'b0;
    always #5 CLK_IN = ~CLK_IN;

    task automatic tick();
        @(posedge CLK_IN);
        #1;
    endtask

    function automatic int gidx(input logic [3:0] g);
        for (int i = 0; i < 4; i++) if (g[i]) return i;
        return -1;
    endfunction

    task automatic test_reset();
        n_checks++;
        if ({gnt, rvalid, busy, ram_cs, ram_oe, ram_we} !== 12'h000) begin
            n_errors++;
            $display("FAIL reset_ctrl: got %h expected 000", {gnt, rvalid, busy, ram_cs, ram_oe, ram_we});
        end
        n_checks++;
        if ({ram_ad, ram_d, rdata} !== 32'h0) begin
            n_errors++;
            $display("FAIL reset_data: got %h expected 00000000", {ram_ad, ram_d, rdata});
        end
        n_checks++;
        if ({gnt_rr, rvalid_rr, busy_rr, ram_cs_rr} !== 10'h0) begin
            n_errors++;
            $display("FAIL reset_rr: got %h expected 000", {gnt_rr, rvalid_rr, busy_rr, ram_cs_rr});
        end
    endtask

    task automatic test_single_read();
        req = 4'b0010; we = 4'b0000; addr[16 +: 16] = 16'h1234; ram_q = 8'hA5;
        tick();
        n_checks++;
        if ({gnt, ram_cs, ram_oe, ram_we, busy} !== {4'b0010, 4'b1101}) begin
            n_errors++;
            $display("FAIL read_grant: got gnt=%b cs/oe/we/busy=%b%b%b%b expected 0010 1101", gnt, ram_cs, ram_oe, ram_we, busy);
        end
        n_checks++;
        if (ram_ad !== 16'h1234) begin
            n_errors++;
            $display("FAIL read_addr: got %h expected 1234", ram_ad);
        end
        req = 4'b0000;
        tick();
        n_checks++;
        if ({gnt, rvalid, ram_cs, ram_oe} !== {8'h00, 2'b11}) begin
            n_errors++;
            $display("FAIL read_cyc1: got gnt=%b rvalid=%b cs=%b oe=%b expected 0000 0000 1 1", gnt, rvalid, ram_cs, ram_oe);
        end
        tick();
        n_checks++;
        if ({rvalid, rdata, ram_cs, ram_oe, busy} !== {4'b0010, 8'hA5, 3'b000}) begin
            n_errors++;
            $display("FAIL read_rvalid: got rvalid=%b rdata=%h cs/oe/busy=%b%b%b expected 0010 a5 000", rvalid, rdata, ram_cs, ram_oe, busy);
        end
        n_checks++;
        if ({rvalid_rr, rdata_rr} !== {4'b0010, 8'hA5}) begin
            n_errors++;
            $display("FAIL read_rvalid_rr: got %b %h expected 0010 a5", rvalid_rr, rdata_rr);
        end
        ram_q = 8'h3C;
        tick();
        n_checks++;
        if ({rvalid, rdata} !== {4'b0000, 8'hA5}) begin
            n_errors++;
            $display("FAIL read_pulse: got rvalid=%b rdata=%h expected 0000 a5", rvalid, rdata);
        end
    endtask

    task automatic test_write();
        req = 4'b0100; we = 4'b0100; addr[32 +: 16] = 16'h0400; wdata[16 +: 8] = 8'h5C;
        tick();
        n_checks++;
        if ({gnt, ram_cs, ram_oe, ram_we} !== {4'b0100, 3'b101}) begin
            n_errors++;
            $display("FAIL write_grant: got gnt=%b cs/oe/we=%b%b%b expected 0100 101", gnt, ram_cs, ram_oe, ram_we);
        end
        n_checks++;
        if ({ram_ad, ram_d} !== {16'h0400, 8'h5C}) begin
            n_errors++;
            $display("FAIL write_bus: got %h %h expected 0400 5c", ram_ad, ram_d);
        end
        req = 4'b0000; we = 4'b0000;
        tick();
        n_checks++;
        if (ram_we !== 1'b1) begin
            n_errors++;
            $display("FAIL write_we2: got %b expected 1", ram_we);
        end
        tick();
        n_checks++;
        if ({ram_we, rvalid, rdata, ram_ad} !== {1'b0, 4'b0000, 8'hA5, 16'h0400}) begin
            n_errors++;
            $display("FAIL write_end: got we=%b rvalid=%b rdata=%h ad=%h expected 0 0000 a5 0400", ram_we, rvalid, rdata, ram_ad);
        end
    endtask

    task automatic test_rr_wrap();
        // pointer is 3 here after the ch2 grant
        req = 4'b1010; we = 4'b0000; addr[48 +: 16] = 16'h0030; addr[16 +: 16] = 16'h0010;
        tick();
        n_checks++;
        if ({gnt, gnt_rr} !== 8'b1000_1000) begin
            n_errors++;
            $display("FAIL wrap_first: got %b %b expected 1000 1000", gnt, gnt_rr);
        end
        req = 4'b0010;
        tick();
        n_checks++;
        if (gnt !== 4'b0000) begin
            n_errors++;
            $display("FAIL wrap_gap1: got %b expected 0000", gnt);
        end
        tick();
        n_checks++;
        if (gnt !== 4'b0000) begin
            n_errors++;
            $display("FAIL wrap_gap2: got %b expected 0000", gnt);
        end
        tick();
        n_checks++;
        if ({gnt, gnt_rr, ram_ad} !== {8'b0010_0010, 16'h0010}) begin
            n_errors++;
            $display("FAIL wrap_second: got %b %b ad=%h expected 0010 0010 0010", gnt, gnt_rr, ram_ad);
        end
        req = 4'b0000;
        tick();
        tick();
        tick();
    endtask

    task automatic test_reset_mid_access();
        req = 4'b0010; we = 4'b0000;
        tick();
        n_checks++;
        if (gnt !== 4'b0010) begin
            n_errors++;
            $display("FAIL abort_grant: got %b expected 0010", gnt);
        end
        req = 4'b0000;
        tick();
        RESETn = 1'b0;
        #1;
        n_checks++;
        if ({ram_cs, ram_oe, busy, ram_cs_rr, busy_rr} !== 5'b0) begin
            n_errors++;
            $display("FAIL abort_strobes: got %b expected 00000", {ram_cs, ram_oe, busy, ram_cs_rr, busy_rr});
        end
        tick();
        n_checks++;
        if ({rvalid, rvalid_rr} !== 8'h00) begin
            n_errors++;
            $display("FAIL abort_rvalid: got %b %b expected 0000 0000", rvalid, rvalid_rr);
        end
        RESETn = 1'b1;
        tick();
        tick();
        n_checks++;
        if ({rvalid, gnt, busy, ram_cs} !== 10'h0) begin
            n_errors++;
            $display("FAIL abort_after: got %b expected 0000000000", {rvalid, gnt, busy, ram_cs});
        end
    endtask

    task automatic test_priority_rr();
        int g0[$];
        int g1[$];
        int exp_rr[5] = '{1, 2, 3, 0, 1};
        req = 4'b1111; we = 4'b0000;
        for (int c = 0; c < 20; c++) begin
            tick();
            if (gnt != 4'b0000) g0.push_back(gidx(gnt));
            if (gnt_rr != 4'b0000) g1.push_back(gidx(gnt_rr));
        end
        for (int i = 0; i < 3; i++) begin
            n_checks++;
            if (i >= g0.size()) begin
                n_errors++;
                $display("FAIL prio_order[%0d]: got no grant expected 0", i);
            end else if (g0[i] !== 0) begin
                n_errors++;
                $display("FAIL prio_order[%0d]: got %0d expected 0", i, g0[i]);
            end
        end
        for (int i = 0; i < 5; i++) begin
            n_checks++;
            if (i >= g1.size()) begin
                n_errors++;
                $display("FAIL rr_order[%0d]: got no grant expected %0d", i, exp_rr[i]);
            end else if (g1[i] !== exp_rr[i]) begin
                n_errors++;
                $display("FAIL rr_order[%0d]: got %0d expected %0d", i, g1[i], exp_rr[i]);
            end
        end
        req = 4'b0000;
        tick();
        tick();
        tick();
    endtask

`ifdef ORIC_RAM_ARB_WPROT_EN
    task automatic test_wprot();
        wprot = 1'b1;
        req = 4'b0010; we = 4'b0010; addr[16 +: 16] = 16'hC010; wdata[8 +: 8] = 8'h77;
        tick();
        n_checks++;
        if ({gnt, wp_hit, ram_cs, ram_we} !== {4'b0010, 3'b110}) begin
            n_errors++;
            $display("FAIL wp_block: got gnt=%b hit=%b cs=%b we=%b expected 0010 1 1 0", gnt, wp_hit, ram_cs, ram_we);
        end
        req = 4'b0000; we = 4'b0000;
        tick();
        n_checks++;
        if ({wp_hit, ram_we, ram_cs} !== 3'b001) begin
            n_errors++;
            $display("FAIL wp_block2: got %b expected 001", {wp_hit, ram_we, ram_cs});
        end
        tick();
        tick();
        req = 4'b0010; we = 4'b0010; addr[16 +: 16] = 16'hBFFF;
        tick();
        n_checks++;
        if ({gnt, wp_hit, ram_we} !== {4'b0010, 2'b01}) begin
            n_errors++;
            $display("FAIL wp_below: got gnt=%b hit=%b we=%b expected 0010 0 1", gnt, wp_hit, ram_we);
        end
        req = 4'b0000; we = 4'b0000; wprot = 1'b0;
        tick();
        tick();
        tick();
    endtask
`endif

    initial begin
        RESETn = 1'b0; req = '0; we = '0; addr = '0; wdata = '0; ram_q = '0;
`ifdef ORIC_RAM_ARB_WPROT_EN
        wprot = 1'b0;
`endif
        tick();
        tick();
        test_reset();
        RESETn = 1'b1;
        tick();
        test_single_read();
        test_write();
        test_rr_wrap();
        test_reset_mid_access();
        test_priority_rr();
`ifdef ORIC_RAM_ARB_WPROT_EN
        test_wprot();
`endif
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

`default_nettype wire
